// File: rtl/karatsuba_pkg.sv
// Shared widths, defaults and FSM encoding for the Karatsuba multiplier issue stage.
package karatsuba_pkg;
    localparam int KW          = 32;
    localparam int KPW         = 2 * KW;
    localparam int KMUL_LAT    = 6;
    localparam int KFIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_CAPT,
        ST_OUT
    } issue_state_e;
endpackage

// File: rtl/karatsuba_operand_fifo.sv
// Operand-pair FIFO: one extra pointer bit separates full from empty.
module karatsuba_operand_fifo
    import karatsuba_pkg::*;
#(
    parameter int DEPTH = KFIFO_DEPTH,
    parameter int DW    = KPW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wrPtr_q;
    logic [AW:0]   rdPtr_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic          pushOk;
    logic          popOk;

    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign pushOk  = push_i && !full_o;
    assign popOk   = pop_i && !empty_o;
    assign data_o  = mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (pushOk) wrPtr_q <= wrPtr_q + (AW+1)'(1);
            if (popOk)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (pushOk) mem_q[wrPtr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/karatsuba_issue_stage.sv
// Issue stage: queues operand pairs, sequences the multiplier's rst/enable run and holds the product.
module karatsuba_issue_stage
    import karatsuba_pkg::*;
#(
    parameter int W          = KW,
    parameter int FIFO_DEPTH = KFIFO_DEPTH,
    parameter int MUL_LAT    = KMUL_LAT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           mul_rst,
    output logic           mul_enable,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [2*W-1:0] mul_c,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res_c
);
    localparam int CW = $clog2(MUL_LAT + 1);

    issue_state_e   state_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [W-1:0]   mulA_q;
    logic [W-1:0]   mulB_q;
    logic [2*W-1:0] resC_q;
    logic           mulRst_q;
    logic           mulEnable_q;
    logic           resValid_q;

    logic           fifoFull;
    logic           fifoEmpty;
    logic           pop;
    logic [2*W-1:0] fifoHead;

    assign in_ready = !fifoFull;
    assign pop      = (state_q == ST_IDLE) && !fifoEmpty;
    assign cnt_d    = cnt_q + CW'(1);

    karatsuba_operand_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (2 * W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid && !fifoFull),
        .data_i  ({in_a, in_b}),
        .pop_i   (pop),
        .data_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Outputs are registered alongside the state so each takes its value for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mulA_q      <= '0;
            mulB_q      <= '0;
            resC_q      <= '0;
            mulRst_q    <= 1'b1;
            mulEnable_q <= 1'b0;
            resValid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        mulA_q  <= fifoHead[2*W-1:W];
                        mulB_q  <= fifoHead[W-1:0];
                        state_q <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    cnt_q       <= '0;
                    mulRst_q    <= 1'b0;
                    mulEnable_q <= 1'b1;
                    state_q     <= ST_RUN;
                end
                ST_RUN: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == CW'(MUL_LAT - 1)) begin
                        mulEnable_q <= 1'b0;
                        state_q     <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    resC_q     <= mul_c;
                    resValid_q <= 1'b1;
                    state_q    <= ST_OUT;
                end
                ST_OUT: begin
                    if (res_ready) begin
                        resValid_q <= 1'b0;
                        mulRst_q   <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    mulRst_q    <= 1'b1;
                    mulEnable_q <= 1'b0;
                    resValid_q  <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign mul_rst    = mulRst_q;
    assign mul_enable = mulEnable_q;
    assign mul_a      = mulA_q;
    assign mul_b      = mulB_q;
    assign res_valid  = resValid_q;
    assign res_c      = resC_q;
endmodule

// File: tb/tb_karatsuba_issue_stage.sv
// Randomized self-checking bench: a queue/countdown model of the stage plus a cycle-exact multiplier model.
module tb_karatsuba_issue_stage;
    localparam int W       = 32;
    localparam int DEPTH   = 4;
    localparam int MUL_LAT = 6;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           mul_rst;
    logic           mul_enable;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [2*W-1:0] mul_c;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [2*W-1:0] res_c;

    int nVectors = 0;
    int nMiscompares = 0;

    always #5 clk = ~clk;

    karatsuba_issue_stage #(
        .W          (W),
        .FIFO_DEPTH (DEPTH),
        .MUL_LAT    (MUL_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_rst    (mul_rst),
        .mul_enable (mul_enable),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_c      (mul_c),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_c      (res_c)
    );

    function automatic logic [63:0] mult(input logic [W-1:0] a, input logic [W-1:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Multiplier stand-in: the true product appears only after exactly MUL_LAT enabled cycles.
    int mulCnt = 0;
    assign mul_c = (mulCnt == MUL_LAT) ? mult(mul_a, mul_b) : ~mult(mul_a, mul_b);
    always @(posedge clk) begin
        if (mul_rst) mulCnt <= 0;
        else if (mul_enable) mulCnt <= mulCnt + 1;
    end

    // Reference model: a queue of waiting pairs, one pair in service with a countdown to its result.
    pair_t       modelQ[$];
    bit          mIdle = 1'b1;
    bit          mOut = 1'b0;
    int          mCount = 0;
    logic [W-1:0] mA = '0;
    logic [W-1:0] mB = '0;
    logic [63:0] mRes = '0;
    logic [63:0] resLog[$];
    int          resCyc[$];
    int          cyc = 0;

    task automatic modelReset();
        modelQ.delete();
        mIdle = 1'b1;
        mOut = 1'b0;
        mCount = 0;
        mA = '0;
        mB = '0;
        mRes = '0;
    endtask

    task automatic modelStep();
        bit expReady;
        bit doPop;
        pair_t p;
        expReady = (modelQ.size() < DEPTH);
        doPop = mIdle && (modelQ.size() != 0);
        if (res_valid && res_ready) begin
            resLog.push_back(res_c);
            resCyc.push_back(cyc);
        end
        if (!mIdle && !mOut) begin
            mCount--;
            if (mCount == 0) begin
                mOut = 1'b1;
                mRes = mult(mA, mB);
            end
        end else if (mOut && res_ready) begin
            mOut = 1'b0;
            mIdle = 1'b1;
        end
        if (doPop) begin
            p = modelQ.pop_front();
            mA = p.a;
            mB = p.b;
            mIdle = 1'b0;
            mCount = MUL_LAT + 2;
        end
        if (in_valid && expReady) begin
            p.a = in_a;
            p.b = in_b;
            modelQ.push_back(p);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) modelReset();
        else modelStep();
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL %s: timed out waiting, got no event, expected one (t=%0t)", name, $time);
    endtask

    initial forever begin
        @(negedge clk);
        checkOutput("in_ready",   64'(in_ready),   64'(modelQ.size() < DEPTH));
        checkOutput("res_valid",  64'(res_valid),  64'(mOut));
        checkOutput("mul_rst",    64'(mul_rst),    64'(mIdle || (!mOut && mCount == MUL_LAT + 2)));
        checkOutput("mul_enable", 64'(mul_enable),
                    64'(!mIdle && !mOut && mCount >= 2 && mCount <= MUL_LAT + 1));
        checkOutput("mul_a",      64'(mul_a),      64'(mA));
        checkOutput("mul_b",      64'(mul_b),      64'(mB));
        checkOutput("res_c",      res_c,           mRes);
    end

    // Offer one pair; returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        bit done;
        int waitCyc;
        done = 1'b0;
        waitCyc = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!done) begin
            @(posedge clk);
            if (in_ready) done = 1'b1;
            else if (++waitCyc > 300) begin
                reportTimeout("push");
                done = 1'b1;
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (!(modelQ.size() == 0 && mIdle && !mOut)) begin
            @(negedge clk);
            if (++n > 600) begin
                reportTimeout("drain");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkLog(input string name, input int idx, input logic [63:0] exp);
        if (idx >= resLog.size()) reportTimeout(name);
        else checkOutput(name, resLog[idx], exp);
    endtask

    function automatic logic [W-1:0] randOperand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int acc;
        int n0;
        int accCnt;
        bit seen;
        pair_t pairs[6];
        logic [63:0] expList[$];
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready",   64'(in_ready),   64'd1);
        checkOutput("rst_res_valid",  64'(res_valid),  64'd0);
        checkOutput("rst_mul_rst",    64'(mul_rst),    64'd1);
        checkOutput("rst_mul_enable", 64'(mul_enable), 64'd0);
        checkOutput("rst_res_c",      res_c,           64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;

        // Single pair: latency and product.
        applyStimulus(32'h0000FFFF, 32'h0000FFFF);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (res_valid) seen = 1'b1;
        end
        if (!seen) reportTimeout("t1_res_valid");
        checkOutput("t1_latency", 64'(lat), 64'd10);
        checkOutput("t1_res_c", res_c, 64'h00000000FFFE0001);
        waitDrain();

        // Back-to-back pairs, one result every MUL_LAT+4 cycles.
        n0 = resLog.size();
        applyStimulus(32'h00000002, 32'h00000003);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF);
        applyStimulus(32'h00010000, 32'h00010000);
        waitDrain();
        checkLog("t2_res0", n0,     64'h0000000000000006);
        checkLog("t2_res1", n0 + 1, 64'hFFFFFFFE00000001);
        checkLog("t2_res2", n0 + 2, 64'h0000000100000000);
        if (resCyc.size() >= n0 + 3) begin
            checkOutput("t2_gap01", 64'(resCyc[n0+1] - resCyc[n0]),   64'd10);
            checkOutput("t2_gap12", 64'(resCyc[n0+2] - resCyc[n0+1]), 64'd10);
        end else reportTimeout("t2_gap");

        // Back-pressure: one in flight plus DEPTH buffered, then a refused push at full with a pop.
        res_ready = 1'b0;
        n0 = resLog.size();
        for (int k = 0; k < 6; k++) begin
            pairs[k].a = 32'(k + 100);
            pairs[k].b = 32'(3 * k + 1);
        end
        acc = 0;
        in_valid = 1'b1;
        in_a = pairs[0].a;
        in_b = pairs[0].b;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            if (in_ready) acc++;
            #1;
            in_a = pairs[acc].a;
            in_b = pairs[acc].b;
        end
        @(negedge clk);
        checkOutput("t3_accepted", 64'(acc), 64'd5);
        checkOutput("t3_in_ready_full", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 res_ready = 1'b1;
        applyStimulus(pairs[5].a, pairs[5].b);
        waitDrain();
        for (int k = 0; k < 6; k++) checkLog("t3_order", n0 + k, mult(pairs[k].a, pairs[k].b));

        // Asynchronous reset in the third RUN cycle with two pairs still queued.
        applyStimulus(32'd11, 32'd13);
        applyStimulus(32'd17, 32'd19);
        applyStimulus(32'd23, 32'd29);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (mul_enable) seen = 1'b1;
        end
        if (!seen) reportTimeout("t5_run");
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("t5_res_valid",  64'(res_valid),  64'd0);
        checkOutput("t5_in_ready",   64'(in_ready),   64'd1);
        checkOutput("t5_mul_rst",    64'(mul_rst),    64'd1);
        checkOutput("t5_mul_enable", 64'(mul_enable), 64'd0);
        checkOutput("t5_mul_a",      64'(mul_a),      64'd0);
        checkOutput("t5_res_c",      res_c,           64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        n0 = resLog.size();
        repeat (20) @(posedge clk);
        checkOutput("t5_no_result", 64'(resLog.size()), 64'(n0));
        #1;
        applyStimulus(32'd5, 32'd7);
        waitDrain();
        checkLog("t5_res_35", n0, 64'd35);

        // Fill and drain repeatedly so the pointers wrap.
        for (int rep = 0; rep < 3; rep++) begin
            res_ready = 1'b0;
            n0 = resLog.size();
            expList.delete();
            for (int k = 0; k < 5; k++) begin
                ra = randOperand();
                rb = randOperand();
                expList.push_back(mult(ra, rb));
                applyStimulus(ra, rb);
            end
            res_ready = 1'b1;
            waitDrain();
            for (int k = 0; k < 5; k++) checkLog("t6_wrap", n0 + k, expList[k]);
        end

        // Random traffic with random back-pressure.
        n0 = resLog.size();
        accCnt = 0;
        for (int c = 0; c < 500; c++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_a = randOperand();
            in_b = randOperand();
            res_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            if (in_valid && in_ready) accCnt++;
            #1;
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        waitDrain();
        checkOutput("rand_count", 64'(resLog.size() - n0), 64'(accCnt));

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
